// File: rtl/alu_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and helpers for the ALU command sequencer.
//               - seq_state_t  : sequencer FSM states
//               - OP_NOP/OP_LDI: reserved opcodes, truncated to OP_W by users
//               - cmd_extract  : splits a packed {op, rd, rs1, rs2} command
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } seq_state_t;

    // NOP is opcode zero; LDI is the all-ones opcode of whatever width the
    // instance uses, so users keep the low OP_W bits of OP_LDI.
    localparam logic [31:0] OP_NOP = 32'h0000_0000;
    localparam logic [31:0] OP_LDI = 32'hFFFF_FFFF;

    // Widest command the extractor accepts.
    localparam int MAX_CMD_W = 64;

    typedef struct packed {
        logic [31:0] op;
        logic [31:0] rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } cmd_fields_t;

    // Field split for a command laid out MSB-first as {op, rd, rs1, rs2}.
    // Fields come back zero-extended to 32 bits; callers keep the low bits.
    function automatic cmd_fields_t cmd_extract(
        input logic [MAX_CMD_W-1:0] cmd_word,
        input int                   op_w,
        input int                   addr_w
    );
        cmd_fields_t            f;
        logic [MAX_CMD_W-1:0]   m_addr;
        logic [MAX_CMD_W-1:0]   m_op;
        m_addr = (64'd1 << addr_w) - 64'd1;
        m_op   = (64'd1 << op_w) - 64'd1;
        f.rs2  = 32'(cmd_word & m_addr);
        f.rs1  = 32'((cmd_word >> addr_w) & m_addr);
        f.rd   = 32'((cmd_word >> (2 * addr_w)) & m_addr);
        f.op   = 32'((cmd_word >> (3 * addr_w)) & m_op);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_regfile.sv
`default_nettype none
// ============================================================================
// Module      : seq_regfile
// Description : NREGS x DATA_W register file, asynchronous active-low clear,
//               one synchronous write port and three combinational reads.
// Ports       : clk, reset_n          - clock / async active-low clear
//               we, waddr, wdata      - write port
//               rs1_addr / rs1_data   - operand A read
//               rs2_addr / rs2_data   - operand B read
//               dbg_addr / dbg_data   - debug read
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module seq_regfile #(
    parameter  int DATA_W = 8,
    parameter  int NREGS  = 8,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    // NREGS is a power of two, so every address is in range.
    assign rs1_data = r_regs[rs1_addr];
    assign rs2_data = r_regs[rs2_addr];
    assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Accepts {op, rd, rs1, rs2} commands over valid/ready, reads
//               operands from an internal register file, runs them through an
//               external multi-cycle ALU (start/done) and writes the result
//               back. NOP and LDI bypass the ALU; a stalled ALU is abandoned
//               after TIMEOUT wait cycles and flagged on err.
// Ports       : clk, reset_n                    - clock / async active-low reset
//               cmd_valid, cmd_ready, cmd       - command handshake
//               alu_start, alu_op, alu_a, alu_b - ALU issue side
//               alu_done, alu_result            - ALU return side
//               done, err                       - completion pulse / timeout flag
//               dbg_addr, dbg_data              - combinational register peek
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module alu_cmd_sequencer #(
    parameter  int DATA_W  = 8,
    parameter  int NREGS   = 8,
    parameter  int OP_W    = 3,
    parameter  int TIMEOUT = 16,
    localparam int ADDR_W  = $clog2(NREGS),
    localparam int CMD_W   = OP_W + 3 * ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd,
    output logic              alu_start,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import alu_seq_pkg::*;

    localparam int              IMM_W      = 2 * ADDR_W;
    localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [OP_W-1:0] C_OP_NOP   = OP_NOP[OP_W-1:0];
    localparam logic [OP_W-1:0] C_OP_LDI   = OP_LDI[OP_W-1:0];
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [OP_W-1:0]   r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    cmd_fields_t       w_fields;
    logic              w_unused_fields;
    logic [OP_W-1:0]   w_op;
    logic [ADDR_W-1:0] w_rd;
    logic [ADDR_W-1:0] w_rs1;
    logic [ADDR_W-1:0] w_rs2;
    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic              w_accept;
    logic              w_capture;
    logic              w_timeout;
    logic              w_we;

    assign w_fields        = cmd_extract(MAX_CMD_W'(cmd), OP_W, ADDR_W);
    assign w_unused_fields = ^w_fields;
    assign w_op            = w_fields.op[OP_W-1:0];
    assign w_rd            = w_fields.rd[ADDR_W-1:0];
    assign w_rs1           = w_fields.rs1[ADDR_W-1:0];
    assign w_rs2           = w_fields.rs2[ADDR_W-1:0];
    assign w_imm           = {w_rs1, w_rs2};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        alu_start = 1'b0;
        done      = 1'b0;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if ((w_op == C_OP_NOP) || (w_op == C_OP_LDI)) begin
                        w_next = WB;
                    end else begin
                        w_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                alu_start = 1'b1;
                w_next    = WAIT;
            end
            WAIT: begin
                // A result arriving on the last permitted cycle still wins.
                if (alu_done) begin
                    w_capture = 1'b1;
                    w_next    = WB;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = WB;
                end
            end
            WB: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= '0;
            r_rd    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= w_op;
                r_rd    <= w_rd;
                r_a     <= w_rs1_data;
                r_b     <= w_rs2_data;
                r_err   <= 1'b0;
                // Immediate staged for LDI; ALU ops overwrite it on capture.
                r_wdata <= DATA_W'(w_imm);
            end
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_wdata <= alu_result;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // r_err is cleared at accept, so in WB it marks a timeout of this command.
    assign w_we   = (r_state == WB) && (r_op != C_OP_NOP) && !r_err;

    assign alu_op = r_op;
    assign alu_a  = r_a;
    assign alu_b  = r_b;
    assign err    = r_err;

    seq_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (w_we),
        .waddr    (r_rd),
        .wdata    (r_wdata),
        .rs1_addr (w_rs1),
        .rs1_data (w_rs1_data),
        .rs2_addr (w_rs2),
        .rs2_data (w_rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer. A default instance
//               (8-bit, 8 regs, 3-bit ops) runs a directed table, a
//               back-to-back sequence, a mid-operation reset and random
//               commands against a register-level reference model; a second
//               instance (16-bit, 16 regs, 4-bit ops) covers the wide build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    // default instance
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd = '0;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [7:0]  alu_result;
    logic        done;
    logic        err;
    logic [2:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    // wide instance
    logic        cmd_valid2 = 1'b0;
    logic        cmd_ready2;
    logic [15:0] cmd2 = '0;
    logic        alu_start2;
    logic [3:0]  alu_op2;
    logic [15:0] alu_a2;
    logic [15:0] alu_b2;
    logic        alu_done2 = 1'b0;
    logic [15:0] alu_result2 = '0;
    logic        done2;
    logic        err2;
    logic [3:0]  dbg_addr2 = '0;
    logic [15:0] dbg_data2;

    // external ALU model
    int          alu_k = 0;
    int          model_wait;
    logic        model_done = 1'b0;
    logic        stray_done = 1'b0;
    logic [7:0]  model_res = '0;
    logic [7:0]  model_tmp;

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  ref_regs [8];

    assign alu_done   = model_done | stray_done;
    assign alu_result = model_res;

    always #5 clk = ~clk;

    alu_cmd_sequencer u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .done       (done),
        .err        (err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    alu_cmd_sequencer #(
        .DATA_W (16),
        .NREGS  (16),
        .OP_W   (4)
    ) u_dut_wide (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid2),
        .cmd_ready  (cmd_ready2),
        .cmd        (cmd2),
        .alu_start  (alu_start2),
        .alu_op     (alu_op2),
        .alu_a      (alu_a2),
        .alu_b      (alu_b2),
        .alu_done   (alu_done2),
        .alu_result (alu_result2),
        .done       (done2),
        .err        (err2),
        .dbg_addr   (dbg_addr2),
        .dbg_data   (dbg_data2)
    );

    // ------------------------------------------------------------ helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return {a[3:0], b[7:4]};
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit is_alu_op(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

    function automatic bit times_out(input logic [2:0] op, input int k);
        return is_alu_op(op) && ((k < 0) || (k > TO - 1));
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input int k);
        if (!is_alu_op(op)) return 1;
        if (times_out(op, k)) return TO + 2;
        return 3 + k;
    endfunction

    // Value register rd should hold after the command completes.
    function automatic logic [7:0] model_next_val(input logic [2:0] op, input logic [2:0] rd,
                                                  input logic [2:0] rs1, input logic [2:0] rs2,
                                                  input int k);
        logic [5:0] imm;
        imm = {rs1, rs2};
        if (op == 3'd7) return 8'(imm);
        if (op == 3'd0) return ref_regs[rd];
        if (times_out(op, k)) return ref_regs[rd];
        return alu_fn(op, ref_regs[rs1], ref_regs[rs2]);
    endfunction

    // ALU: answers k+1 edges after seeing alu_start, i.e. in WAIT cycle k.
    initial begin
        forever begin
            @(negedge clk);
            if (alu_start === 1'b1 && alu_k >= 0) begin
                model_tmp  = alu_fn(alu_op, alu_a, alu_b);
                model_wait = alu_k;
                repeat (model_wait + 1) @(posedge clk);
                #1;
                model_done = 1'b1;
                model_res  = model_tmp;
                @(posedge clk);
                #1;
                model_done = 1'b0;
            end
        end
    end

    task automatic send(input logic [11:0] c, input bit hold);
        bit ok;
        ok        = 1'b0;
        cmd       = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_wait", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Called just after the accept edge; cycle 1 is the first after accept.
    task automatic track(output int lat, output int ns, output logic [7:0] sa,
                         output logic [7:0] sb, output logic e, output int nr);
        lat = 0; ns = 0; sa = '0; sb = '0; e = 1'b0; nr = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (alu_start) begin
                ns++;
                sa = alu_a;
                sb = alu_b;
            end
            if (done) begin
                lat = c;
                e   = err;
                break;
            end
            if (cmd_ready) nr++;
        end
    endtask

    task automatic run_check(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input int k, input int x_lat,
                             input logic x_err, input logic [7:0] x_val);
        int         lat;
        int         ns;
        int         nr;
        logic [7:0] sa;
        logic [7:0] sb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       e;
        ea    = ref_regs[rs1];
        eb    = ref_regs[rs2];
        alu_k = k;
        send({op, rd, rs1, rs2}, 1'b0);
        track(lat, ns, sa, sb, e, nr);
        chk("latency", 32'(lat), 32'(x_lat));
        chk("err_at_done", 32'(e), 32'(x_err));
        chk("start_count", 32'(ns), is_alu_op(op) ? 32'd1 : 32'd0);
        if (is_alu_op(op)) begin
            chk("alu_a", 32'(sa), 32'(ea));
            chk("alu_b", 32'(sb), 32'(eb));
        end
        @(posedge clk);
        #1;
        dbg_addr = rd;
        #1;
        chk("wb_value", 32'(dbg_data), 32'(x_val));
        chk("err_sticky", 32'(err), 32'(x_err));
    endtask

    task automatic send2(input logic [15:0] c, output int lat, output int ns);
        bit ok;
        ok         = 1'b0;
        cmd2       = c;
        cmd_valid2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wide_accept_wait", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid2 = 1'b0;
        lat = 0;
        ns  = 0;
        for (int c2 = 1; c2 <= 10; c2++) begin
            @(negedge clk);
            if (alu_start2) ns++;
            if (done2) begin
                lat = c2;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        int         k;
        logic [7:0] val;
        int         lat;
        logic       e;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat;
        int         ns;
        int         nr;
        int         nd;
        int         nbusy;
        logic [7:0] sa;
        logic [7:0] sb;
        logic [7:0] va;
        logic [7:0] vb;
        logic       e;
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        int         k;

        //          op    rd    rs1   rs2   k   val    lat  err
        tbl[0] = '{3'd7, 3'd3, 3'd0, 3'd5, 0,  8'h05, 1,   1'b0};
        tbl[1] = '{3'd7, 3'd1, 3'd2, 3'd2, 0,  8'h12, 1,   1'b0};
        tbl[2] = '{3'd7, 3'd2, 3'd6, 3'd4, 0,  8'h34, 1,   1'b0};
        tbl[3] = '{3'd1, 3'd4, 3'd1, 3'd2, 2,  8'h46, 5,   1'b0};
        tbl[4] = '{3'd1, 3'd4, 3'd1, 3'd2, -1, 8'h46, 18,  1'b1};
        tbl[5] = '{3'd0, 3'd4, 3'd7, 3'd7, 0,  8'h46, 1,   1'b0};
        tbl[6] = '{3'd5, 3'd4, 3'd4, 3'd4, 0,  8'h00, 3,   1'b0};
        tbl[7] = '{3'd2, 3'd5, 3'd2, 3'd1, 15, 8'h22, 18,  1'b0};
        tbl[8] = '{3'd7, 3'd7, 3'd7, 3'd7, 0,  8'h3F, 1,   1'b0};

        for (int i = 0; i < 8; i++) ref_regs[i] = '0;

        // ---------------------------------------------------- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk("rst_reg", 32'(dbg_data), 32'd0);
        end

        // ------------------------------------------------- directed table
        for (int i = 0; i < 9; i++) begin
            run_check(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].k,
                      tbl[i].lat, tbl[i].e, tbl[i].val);
            ref_regs[tbl[i].rd] = model_next_val(tbl[i].op, tbl[i].rd, tbl[i].rs1,
                                                 tbl[i].rs2, tbl[i].k);
        end

        // ------------------------------ back-to-back, second reads first rd
        va = model_next_val(3'd1, 3'd6, 3'd1, 3'd2, 1);
        alu_k = 1;
        send({3'd1, 3'd6, 3'd1, 3'd2}, 1'b1);
        cmd = {3'd2, 3'd0, 3'd6, 3'd3};
        track(lat, ns, sa, sb, e, nr);
        chk("b2b_first_latency", 32'(lat), 32'd4);
        chk("b2b_ready_busy", 32'(nr), 32'd0);
        ref_regs[6] = va;
        vb = model_next_val(3'd2, 3'd0, 3'd6, 3'd3, 0);
        alu_k = 0;
        @(posedge clk);
        #1;
        chk("b2b_ready_after_wb", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        track(lat, ns, sa, sb, e, nr);
        chk("b2b_second_latency", 32'(lat), 32'd3);
        chk("b2b_second_start", 32'(ns), 32'd1);
        chk("b2b_alu_a_fwd", 32'(sa), 32'(va));
        ref_regs[0] = vb;
        @(posedge clk);
        #1;
        dbg_addr = 3'd0;
        #1;
        chk("b2b_second_wb", 32'(dbg_data), 32'(vb));

        // ----------------------------------------- reset during WAIT
        alu_k = 3;
        send({3'd1, 3'd6, 3'd1, 3'd2}, 1'b0);
        @(negedge clk);             // ISSUE
        @(negedge clk);             // first WAIT cycle
        reset_n = 1'b0;
        #1;
        chk("midrst_idle", 32'(cmd_ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        dbg_addr = 3'd1;
        #1;
        chk("midrst_regs_clear", 32'(dbg_data), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) ref_regs[i] = '0;
        nd    = 0;
        nbusy = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            stray_done = (c == 5);
            @(negedge clk);
            if (done) nd++;
            if (!cmd_ready) nbusy++;
        end
        stray_done = 1'b0;
        chk("midrst_no_done", 32'(nd), 32'd0);
        chk("midrst_stays_idle", 32'(nbusy), 32'd0);
        dbg_addr = 3'd6;
        #1;
        chk("midrst_no_wb", 32'(dbg_data), 32'd0);
        @(posedge clk);
        #1;

        // ------------------------------------------------- random commands
        for (int n = 0; n < 30; n++) begin
            op  = 3'($urandom_range(0, 7));
            rd  = 3'($urandom_range(0, 7));
            rs1 = 3'($urandom_range(0, 7));
            rs2 = 3'($urandom_range(0, 7));
            k   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            va  = model_next_val(op, rd, rs1, rs2, k);
            run_check(op, rd, rs1, rs2, k, exp_latency(op, k), times_out(op, k), va);
            ref_regs[rd] = va;
        end

        // ------------------------------------------- wide parameter build
        send2({4'hF, 4'd2, 4'hA, 4'h5}, lat, ns);
        chk("wide_ldi_latency", 32'(lat), 32'd1);
        chk("wide_ldi_no_start", 32'(ns), 32'd0);
        dbg_addr2 = 4'd2;
        #1;
        chk("wide_ldi_value", 32'(dbg_data2), 32'h0000_00A5);
        send2({4'hF, 4'd15, 4'hF, 4'hF}, lat, ns);
        chk("wide_ldi_max_latency", 32'(lat), 32'd1);
        dbg_addr2 = 4'd15;
        #1;
        chk("wide_ldi_max_value", 32'(dbg_data2), 32'h0000_00FF);
        send2({4'h0, 4'd2, 4'h0, 4'h0}, lat, ns);
        chk("wide_nop_latency", 32'(lat), 32'd1);
        chk("wide_nop_no_start", 32'(ns), 32'd0);
        dbg_addr2 = 4'd2;
        #1;
        chk("wide_nop_no_write", 32'(dbg_data2), 32'h0000_00A5);
        dbg_addr2 = 4'd3;
        #1;
        chk("wide_untouched_reg", 32'(dbg_data2), 32'd0);
        chk("wide_err", 32'(err2), 32'd0);
        chk("wide_alu_op_latched", 32'(alu_op2), 32'd0);
        chk("wide_alu_a_latched", 32'(alu_a2), 32'd0);
        chk("wide_alu_b_latched", 32'(alu_b2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Parametrised successor to the fixed 12-bit ALU command controller. It accepts packed commands {opcode, rd, rs1, rs2} over a valid/ready handshake and holds an NREGS x DATA_W register file. Each command reads its operands, issues them to an external multi-cycle ALU over a start/done handshake and writes the result back. It adds LDI (load immediate), NOP, an ALU timeout with an error flag, and a debug read port.

Parameters:
DATA_W, 8, register and ALU data width
NREGS, 8, register count; power of two, at least 2
OP_W, 3, opcode width
TIMEOUT, 16, maximum WAIT cycles before abort; at least 1
ADDR_W (localparam), $clog2(NREGS), register address width
CMD_W (localparam), OP_W+3*ADDR_W, command width

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd  in  CMD_W  fields from MSB: op, rd, rs1, rs2
alu_start  out  1  one-cycle issue pulse
alu_op  out  OP_W  opcode to the ALU, held from ISSUE through WAIT
alu_a  out  DATA_W  operand regs[rs1], held
alu_b  out  DATA_W  operand regs[rs2], held
alu_done  in  1  ALU result valid, one-cycle pulse
alu_result  in  DATA_W  ALU result
done  out  1  one-cycle completion pulse per command
err  out  1  last command timed out
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  regs[dbg_addr], combinational

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; all registers 0; alu_start, done and err are 0; alu_op, alu_a, alu_b and the timeout counter are 0. A reset in mid-operation aborts the command with no write-back. An ALU result returned later is ignored because the sequencer is in IDLE.
- FSM states: IDLE, ISSUE, WAIT, WB.
- cmd_ready = (state == IDLE). A command is accepted when cmd_valid && cmd_ready on a rising clock edge.
- On accept, the sequencer latches op and rd, latches alu_a = regs[rs1] and alu_b = regs[rs2], and clears err.
- Opcode map:
  - 0 = NOP: IDLE -> WB, no write.
  - OP_W'(all ones) = LDI: IDLE -> WB; writes zero-extended {rs1, rs2} (2*ADDR_W bits; truncated if wider than DATA_W) into rd.
  - Every other opcode is passed to the ALU: IDLE -> ISSUE.
- ISSUE: alu_start = 1 for exactly this cycle; the timeout counter is cleared; next state is WAIT.
- WAIT: alu_done is sampled starting the cycle after ISSUE.
  - On alu_done: latch alu_result, then go to WB.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without alu_done, set err = 1 and go to WB with the write suppressed.
- WB: writes the latched value to regs[rd] unless the command was a NOP or timed out; done = 1; next state is IDLE.
- Latency from accept to done:
  - NOP or LDI: 1 cycle.
  - ALU ops: 3 + k cycles, where k is the number of WAIT cycles before alu_done (k = 0 if done arrives in the first WAIT cycle).
- Back-to-back: cmd_ready rises in the cycle after WB. A command reading the register written in the previous WB sees the new value.
- Cycles with alu_done outside WAIT are ignored.
- err is sticky until the next command is accepted.
- dbg_data reflects a WB write from the cycle after the write edge.
- rd == rs1 == rs2 is legal because operands are latched at accept.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum: IDLE, ISSUE, WAIT, WB;
  - opcode constants OP_NOP and OP_LDI;
  - a cmd field-extract function parameterised by OP_W and ADDR_W.
- Sub-module seq_regfile: NREGS x DATA_W storage with async active-low clear, 1 write port and 3 combinational read ports (rs1, rs2, dbg).

Test Plan:
- Reset, then LDI rd=3 imm=6'b000101 -> done 1 cycle after accept; dbg_addr=3 gives dbg_data = 8'h05; alu_start never asserted.
- Preload r1 = 8'h12 and r2 = 8'h34, then op=1 rd=4 rs1=1 rs2=2 with the ALU model returning a+b after 2 WAIT cycles:
  - alu_start pulses once with alu_a = 8'h12 and alu_b = 8'h34;
  - done arrives 5 cycles after accept;
  - r4 = 8'h46.
- ALU model never asserts alu_done, TIMEOUT=16 -> err = 1 and done pulse after 16 WAIT cycles; rd unchanged. The next accepted command clears err.
- Back-to-back commands with cmd_valid held high, where the second reads the first's rd:
  - cmd_ready low during the first command;
  - the second command's alu_a equals the first command's result.
- Assert reset_n low during WAIT, then return alu_done after release:
  - registers are 0 and state is IDLE;
  - no write and no done pulse;
  - a stray alu_done is ignored.
- Parameter sweep DATA_W=16, NREGS=16, OP_W=4 -> CMD_W = 16; LDI imm 8'hA5 gives 16'h00A5 and NOP writes nothing.
